// File: rtl/config_bus_arb_if.sv
// ----------------------------------------------------------------------------
// config_bus_arb_if
//   Bundles every bus signal of the config-space arbiter:
//   - SPI side    : spi_w/spi_r strobes, spi_a, spi_d, spi_rdata,
//                   spi_overrun (sticky), overrun_clr
//   - host side   : host_req/host_we/host_a/host_d in, host_ack/host_rdata out
//   - memory side : mem_we/mem_re/mem_a/mem_d out, mem_q in
//   Modports:
//   - slave  : the arbiter itself
//   - master : the surrounding environment (SPI translator, host, register file)
// ----------------------------------------------------------------------------
interface config_bus_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          spi_w;
  logic          spi_r;
  logic [AW-1:0] spi_a;
  logic [DW-1:0] spi_d;
  logic [DW-1:0] spi_rdata;
  logic          spi_overrun;
  logic          overrun_clr;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_a;
  logic [DW-1:0] host_d;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  modport slave (
    input  spi_w, spi_r, spi_a, spi_d, overrun_clr,
    output spi_rdata, spi_overrun,
    input  host_req, host_we, host_a, host_d,
    output host_ack, host_rdata,
    output mem_we, mem_re, mem_a, mem_d,
    input  mem_q
  );

  modport master (
    output spi_w, spi_r, spi_a, spi_d, overrun_clr,
    input  spi_rdata, spi_overrun,
    output host_req, host_we, host_a, host_d,
    input  host_ack, host_rdata,
    input  mem_we, mem_re, mem_a, mem_d,
    output mem_q
  );
endinterface

// File: rtl/config_bus_arb.sv
// ----------------------------------------------------------------------------
// config_bus_arb
//   Shares one config register space between the SPI-side config bus
//   (strobe-only, no backpressure) and a local host port (req/ack handshake).
//   SPI traffic has strict priority. A 1-deep pending slot absorbs one SPI
//   strobe while the memory port is busy; a further strobe is dropped and
//   flagged on the sticky spi_overrun.
//   Ports:
//   - config_clk : sole clock
//   - rst        : asynchronous, active-high reset
//   - bus        : config_bus_arb_if.slave (SPI, host and memory signals)
//   Parameters: AW/DW address/data width, READ_LAT memory read latency (1..3)
// ----------------------------------------------------------------------------
module config_bus_arb #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int READ_LAT = 1
) (
  input  logic            config_clk,
  input  logic            rst,
  config_bus_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SPI_RD, HOST_RD, HOST_GAP} state_t;

  localparam logic [1:0] LAT = 2'(READ_LAT);

  state_t        state, state_n;
  logic [1:0]    cnt, cnt_n;

  logic          slot_full;
  logic          slot_we;
  logic [AW-1:0] slot_a;
  logic [DW-1:0] slot_d;

  logic          strobe;
  logic          slot_release;
  logic          bypass_wr;
  logic          slot_load;
  logic          overrun_set;

  logic          mem_we_n, mem_re_n, host_ack_n;
  logic [AW-1:0] mem_a_n;
  logic [DW-1:0] mem_d_n, spi_rdata_n, host_rdata_n;

  assign strobe = bus.spi_w | bus.spi_r;

  // Slot capture. A slot being released this cycle can take the new strobe.
  // A write strobe issued straight from the inputs never occupies the slot;
  // a read strobe does, and stays there until its data is sampled.
  always_comb begin
    slot_load   = strobe & ~bypass_wr & (~slot_full | slot_release);
    overrun_set = (bus.spi_w & bus.spi_r) | (strobe & slot_full & ~slot_release);
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    mem_we_n     = 1'b0;
    mem_re_n     = 1'b0;
    mem_a_n      = bus.mem_a;
    mem_d_n      = bus.mem_d;
    host_ack_n   = 1'b0;
    spi_rdata_n  = bus.spi_rdata;
    host_rdata_n = bus.host_rdata;
    slot_release = 1'b0;
    bypass_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (slot_full) begin
          mem_a_n = slot_a;
          if (slot_we) begin
            mem_we_n     = 1'b1;
            mem_d_n      = slot_d;
            slot_release = 1'b1;
          end else begin
            mem_re_n = 1'b1;
            cnt_n    = '0;
            state_n  = SPI_RD;
          end
        end else if (strobe) begin
          // Empty slot: serve the strobe in the cycle it arrives.
          mem_a_n = bus.spi_a;
          if (bus.spi_w) begin
            mem_we_n  = 1'b1;
            mem_d_n   = bus.spi_d;
            bypass_wr = 1'b1;
          end else begin
            mem_re_n = 1'b1;
            cnt_n    = '0;
            state_n  = SPI_RD;
          end
        end else if (bus.host_req) begin
          mem_a_n = bus.host_a;
          if (bus.host_we) begin
            mem_we_n   = 1'b1;
            mem_d_n    = bus.host_d;
            host_ack_n = 1'b1;
            state_n    = HOST_GAP;
          end else begin
            mem_re_n = 1'b1;
            cnt_n    = '0;
            state_n  = HOST_RD;
          end
        end
      end
      // cnt is 0 in the mem_re cycle, so mem_q is valid when cnt reaches LAT.
      SPI_RD: begin
        if (cnt == LAT) begin
          spi_rdata_n  = bus.mem_q;
          slot_release = 1'b1;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      HOST_RD: begin
        if (cnt == LAT) begin
          host_rdata_n = bus.mem_q;
          host_ack_n   = 1'b1;
          state_n      = HOST_GAP;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      // Dead cycle that lets the host drop host_req after its ack.
      HOST_GAP: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      slot_full       <= 1'b0;
      bus.spi_overrun <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_re      <= 1'b0;
      bus.mem_a       <= '0;
      bus.mem_d       <= '0;
      bus.host_ack    <= 1'b0;
      bus.spi_rdata   <= '0;
      bus.host_rdata  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (slot_load) begin
        slot_full <= 1'b1;
      end else if (slot_release) begin
        slot_full <= 1'b0;
      end
      // A new overrun wins over a simultaneous clear.
      bus.spi_overrun <= (bus.spi_overrun & ~bus.overrun_clr) | overrun_set;
      bus.mem_we      <= mem_we_n;
      bus.mem_re      <= mem_re_n;
      bus.mem_a       <= mem_a_n;
      bus.mem_d       <= mem_d_n;
      bus.host_ack    <= host_ack_n;
      bus.spi_rdata   <= spi_rdata_n;
      bus.host_rdata  <= host_rdata_n;
    end
  end

  // Slot payload is only meaningful while slot_full is set.
  always_ff @(posedge config_clk) begin
    if (slot_load) begin
      slot_we <= bus.spi_w;
      slot_a  <= bus.spi_a;
      slot_d  <= bus.spi_d;
    end
  end

endmodule
